// File: rtl/fp_posit_mul_ctrl_pkg.sv
// Shared definitions for the posit-weight / FP16-activation multiplier controller.
package fp_posit_mul_ctrl_pkg;

   localparam int W_MAX_DEF = 8;
   localparam int MANT_W    = 14;
   localparam int EXP_W     = 5;
   localparam int PREC_W    = 4;

   localparam logic [PREC_W-1:0] PREC_MIN = 4'd2;
   localparam logic [PREC_W-1:0] PREC_MAX = 4'(W_MAX_DEF);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CFG    = 3'd1,
      ST_STREAM = 3'd2,
      ST_WAIT   = 3'd3,
      ST_OUT    = 3'd4
   } state_t;

   // A posit needs at least sign plus one regime bit, so widths below 2 are lifted.
   function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] req,
                                                    input logic [PREC_W-1:0] lim);
      if (req < PREC_MIN)
         return PREC_MIN;
      else if (req > lim)
         return lim;
      else
         return req;
   endfunction

endpackage

// File: rtl/fp_posit_mul_ctrl_serializer.sv
// Weight latch and MSB-first bit serializer feeding the bit-serial multiplier.
module posit_bit_serializer
   import fp_posit_mul_ctrl_pkg::*;
#(
   parameter int W_MAX = W_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [W_MAX-1:0]  w_in,
   input  logic              en,
   input  logic [PREC_W-1:0] prec,
   output logic              bit_out,
   output logic              last
);

   localparam int CNT_W = (W_MAX > 1) ? $clog2(W_MAX) : 1;

   logic [W_MAX-1:0]  w_q;
   logic [CNT_W-1:0]  cnt;
   logic [PREC_W-1:0] idx;
   logic [W_MAX-1:0]  w_sh;

   // Latch the weight on job accept; count bits while streaming, holding at the last one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_q <= '0;
         cnt <= '0;
      end else if (load) begin
         w_q <= w_in;
         cnt <= '0;
      end else if (en && !last) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Select bit P-1-k so the sign bit goes out first; gate to 0 outside the stream.
   always_comb begin
      idx     = prec - PREC_W'(cnt) - 4'd1;
      w_sh    = w_q >> idx;
      last    = (PREC_W'(cnt) == (prec - 4'd1));
      bit_out = en & w_sh[0];
   end

endmodule

// File: rtl/fp_posit_mul_ctrl.sv
// Sequencer for a bit-serial posit x FP16 multiplier: precision config, weight
// streaming, result capture with timeout, and result handshake.
//
// state  | meaning
// IDLE   | ready for cfg or job (cfg wins); forces a CFG after reset
// CFG    | one-cycle mul_set pulse carrying the latched precision
// STREAM | P cycles of weight bits, MSB first
// WAIT   | waiting for mul_done, bounded by TIMEOUT cycles
// OUT    | result presented until res_ready
module fp_posit_mul_ctrl
   import fp_posit_mul_ctrl_pkg::*;
#(
   parameter int ACT_WIDTH = 16,
   parameter int W_MAX     = W_MAX_DEF,
   parameter int TIMEOUT   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [PREC_W-1:0]    cfg_precision,
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic [ACT_WIDTH-1:0] job_act,
   input  logic [W_MAX-1:0]     job_w,
   output logic                 mul_set,
   output logic [PREC_W-1:0]    mul_precision,
   output logic                 mul_valid,
   output logic [ACT_WIDTH-1:0] mul_act,
   output logic                 mul_w,
   input  logic                 mul_sign,
   input  logic [EXP_W-1:0]     mul_exp,
   input  logic [MANT_W-1:0]    mul_mant,
   input  logic                 mul_done,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 res_sign,
   output logic [EXP_W-1:0]     res_exp,
   output logic [MANT_W-1:0]    res_mant,
   output logic                 busy,
   output logic                 err_timeout
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   state_t              state, state_n;
   logic [PREC_W-1:0]   prec_q;
   logic                need_cfg;
   logic [ACT_WIDTH-1:0] act_q;
   logic [TMR_W-1:0]    wait_tmr;

   logic cfg_acc, job_acc, cap, timeout_hit, tmr_load, tmr_dec;
   logic stream_en, last_bit;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   // Next-state logic and per-state strobes.
   always_comb begin
      state_n       = state;
      cfg_ready     = 1'b0;
      job_ready     = 1'b0;
      mul_set       = 1'b0;
      mul_precision = '0;
      mul_valid     = 1'b0;
      res_valid     = 1'b0;
      cfg_acc       = 1'b0;
      job_acc       = 1'b0;
      cap           = 1'b0;
      timeout_hit   = 1'b0;
      tmr_load      = 1'b0;
      tmr_dec       = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (need_cfg) begin
               state_n = ST_CFG;
            end else begin
               cfg_ready = 1'b1;
               job_ready = 1'b1;
               if (cfg_valid) begin
                  cfg_acc = 1'b1;
                  state_n = ST_CFG;
               end else if (job_valid) begin
                  job_acc = 1'b1;
                  state_n = ST_STREAM;
               end
            end
         end
         ST_CFG: begin
            mul_set       = 1'b1;
            mul_precision = prec_q;
            state_n       = ST_IDLE;
         end
         ST_STREAM: begin
            mul_valid = 1'b1;
            if (last_bit) begin
               tmr_load = 1'b1;
               state_n  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mul_done) begin
               cap     = 1'b1;
               state_n = ST_OUT;
            end else if (wait_tmr == '0) begin
               cap         = 1'b1;
               timeout_hit = 1'b1;
               state_n     = ST_OUT;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_OUT: begin
            res_valid = 1'b1;
            if (res_ready)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Config, activation, result and timeout registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prec_q      <= 4'(W_MAX);
         need_cfg    <= 1'b1;
         act_q       <= '0;
         wait_tmr    <= '0;
         res_sign    <= 1'b0;
         res_exp     <= '0;
         res_mant    <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (state == ST_CFG)
            need_cfg <= 1'b0;
         if (cfg_acc) begin
            prec_q      <= clamp_prec(cfg_precision, 4'(W_MAX));
            err_timeout <= 1'b0;
         end else if (timeout_hit) begin
            err_timeout <= 1'b1;
         end
         if (job_acc)
            act_q <= job_act;
         if (tmr_load)
            wait_tmr <= TMR_W'(TIMEOUT - 1);
         else if (tmr_dec)
            wait_tmr <= wait_tmr - TMR_W'(1);
         if (cap) begin
            res_sign <= mul_sign;
            res_exp  <= mul_exp;
            res_mant <= mul_mant;
         end
      end
   end

   assign stream_en = (state == ST_STREAM);
   assign busy      = (state != ST_IDLE);
   assign mul_act   = act_q;

   posit_bit_serializer #(
      .W_MAX (W_MAX)
   ) u_ser (
      .clk     (clk),
      .rst     (rst),
      .load    (job_acc),
      .w_in    (job_w),
      .en      (stream_en),
      .prec    (prec_q),
      .bit_out (mul_w),
      .last    (last_bit)
   );

endmodule

// File: tb/tb_fp_posit_mul_ctrl.sv
// Scoreboard bench for fp_posit_mul_ctrl with a behavioural bit-serial multiplier.
module tb_fp_posit_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid, cfg_ready;
   logic [3:0]  cfg_precision;
   logic        job_valid, job_ready;
   logic [15:0] job_act;
   logic [7:0]  job_w;
   logic        mul_set;
   logic [3:0]  mul_precision;
   logic        mul_valid;
   logic [15:0] mul_act;
   logic        mul_w;
   logic        mul_sign;
   logic [4:0]  mul_exp;
   logic [13:0] mul_mant;
   logic        mul_done;
   logic        res_valid, res_ready;
   logic        res_sign;
   logic [4:0]  res_exp;
   logic [13:0] res_mant;
   logic        busy, err_timeout;

   int n_checks = 0;
   int n_fail   = 0;
   int cur_p    = 8;
   int mdl_delay = 1;
   bit mdl_en   = 1'b1;
   bit mdl_spur = 1'b0;
   logic [20:0] sb[$];

   always #5 clk = ~clk;

   fp_posit_mul_ctrl #(.ACT_WIDTH(16), .W_MAX(8), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_precision(cfg_precision),
      .job_valid(job_valid), .job_ready(job_ready), .job_act(job_act), .job_w(job_w),
      .mul_set(mul_set), .mul_precision(mul_precision),
      .mul_valid(mul_valid), .mul_act(mul_act), .mul_w(mul_w),
      .mul_sign(mul_sign), .mul_exp(mul_exp), .mul_mant(mul_mant), .mul_done(mul_done),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_sign(res_sign), .res_exp(res_exp), .res_mant(res_mant),
      .busy(busy), .err_timeout(err_timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Stand-in multiplier result: sign xor, exponent act+1, mantissa {act[5:0], weight}.
   function automatic logic [19:0] res_model(input logic [15:0] a, input logic [7:0] w, input int p);
      logic [7:0] wm;
      logic [4:0] e;
      wm = w & 8'((1 << p) - 1);
      e  = a[14:10] + 5'd1;
      return {a[15] ^ wm[p-1], e, a[5:0], wm};
   endfunction

   // Multiplier model: collects streamed bits, drives the result bus, pulses mul_done.
   int         m_cnt = 0;
   int         m_cd  = 0;
   logic [7:0] m_coll = '0;
   always @(negedge clk) begin
      logic [19:0] r;
      mul_done = 1'b0;
      if (!rst) begin
         m_cnt = 0; m_cd = 0; m_coll = '0;
      end else begin
         if (m_cd > 0) begin
            m_cd--;
            if (m_cd == 0) mul_done = 1'b1;
         end
         if (mdl_spur && mul_valid) mul_done = 1'b1;
         if (mul_valid) begin
            m_coll = {m_coll[6:0], mul_w};
            m_cnt++;
            if (m_cnt == cur_p) begin
               r = res_model(mul_act, m_coll, cur_p);
               {mul_sign, mul_exp, mul_mant} = r;
               m_cnt = 0; m_coll = '0;
               if (mdl_en) m_cd = mdl_delay;
            end
         end
      end
   end

   task automatic do_cfg(input logic [3:0] p, input int exp_p);
      @(negedge clk);
      check("cfg_ready", cfg_ready, 1);
      cfg_valid = 1'b1; cfg_precision = p;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("cfg_set", mul_set, 1);
      check("cfg_prec", mul_precision, exp_p);
      check("cfg_err_clr", err_timeout, 0);
      @(negedge clk);
      check("cfg_done", {mul_set, job_ready}, 2'b01);
      cur_p = exp_p;
   endtask

   task automatic run_job(input logic [15:0] act, input logic [7:0] w, input int exp_lat,
                          input logic exp_err, input int hold, input bit poke, input bit spur);
      logic [20:0] e, g;
      int lat;
      @(negedge clk);
      check("job_ready", job_ready, 1);
      job_valid = 1'b1; job_act = act; job_w = w;
      sb.push_back({exp_err, res_model(act, w, cur_p)});
      mdl_spur = spur;
      for (int k = 0; k < cur_p; k++) begin
         @(negedge clk);
         job_valid = poke;
         job_act   = poke ? ~act : act;
         cfg_valid = poke;
         cfg_precision = 4'd3;
         check("stream_valid", mul_valid, 1);
         check("stream_w", mul_w, w[cur_p-1-k]);
         check("stream_act", mul_act, act);
         if (poke) check("busy_reject", {cfg_ready, job_ready, mul_set}, 0);
      end
      cfg_valid = 1'b0; job_valid = 1'b0; mdl_spur = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         check("post_stream_idle", {mul_valid, mul_w, busy}, 3'b001);
         check("act_hold", mul_act, act);
      end while (!res_valid && lat < 20);
      check("res_latency", lat, exp_lat);
      g = {err_timeout, res_sign, res_exp, res_mant};
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("res_data", g, e);
      end else begin
         check("sb_empty", 0, 1);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("bp_stable", {err_timeout, res_sign, res_exp, res_mant}, g);
         check("bp_ready", {res_valid, job_ready, cfg_ready}, 3'b100);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("res_release", {res_valid, job_ready, busy}, 3'b010);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; cfg_valid = 1'b0; cfg_precision = '0; job_valid = 1'b0;
      job_act = '0; job_w = '0; res_ready = 1'b0;
      mul_sign = 1'b0; mul_exp = '0; mul_mant = '0; mul_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outs", {mul_set, mul_valid, mul_w, job_ready, cfg_ready, busy, res_valid, err_timeout}, 0);
      check("rst_prec", mul_precision, 0);
      check("rst_res", {res_sign, res_exp, res_mant, mul_act}, 0);
      rst = 1'b1;
      @(negedge clk);
      check("boot_cfg", {mul_set, mul_precision, job_ready}, {1'b1, 4'd8, 1'b0});
      @(negedge clk);
      check("boot_done", {mul_set, job_ready}, 2'b01);

      do_cfg(4'd4, 4);
      run_job(16'h3C00, 8'h06, 2, 1'b0, 0, 1'b0, 1'b0);
      check("res_exp16", res_exp, 16);
      run_job(16'hC5A3, 8'h09, 2, 1'b0, 5, 1'b0, 1'b0);

      do_cfg(4'd1, 2);
      run_job(16'h4123, 8'h02, 2, 1'b0, 0, 1'b0, 1'b0);
      do_cfg(4'd0, 2);
      run_job(16'h8001, 8'h01, 2, 1'b0, 0, 1'b0, 1'b0);

      do_cfg(4'd15, 8);
      for (int i = 0; i < 3; i++)
         run_job(16'($urandom), 8'($urandom), 2, 1'b0, i, 1'b0, 1'b0);
      do_cfg(4'd8, 8);
      mdl_delay = 3;
      run_job(16'h5A5A, 8'hA7, 4, 1'b0, 0, 1'b0, 1'b0);
      mdl_delay = 4;
      run_job(16'h1234, 8'h3C, 5, 1'b0, 0, 1'b0, 1'b0);
      mdl_delay = 1;

      // cfg and job together in IDLE: cfg wins, job dropped
      @(negedge clk);
      cfg_valid = 1'b1; cfg_precision = 4'd5;
      job_valid = 1'b1; job_act = 16'hFFFF; job_w = 8'hFF;
      @(negedge clk);
      cfg_valid = 1'b0; job_valid = 1'b0;
      check("prio_cfg", {mul_set, mul_precision, mul_valid}, {1'b1, 4'd5, 1'b0});
      @(negedge clk);
      check("prio_nojob", {mul_valid, job_ready, busy}, 3'b010);
      cur_p = 5;
      run_job(16'h2B71, 8'h15, 2, 1'b0, 0, 1'b1, 1'b1);

      // timeout and sticky error
      mdl_en = 1'b0;
      run_job(16'h7C01, 8'h0E, 5, 1'b1, 0, 1'b0, 1'b0);
      mdl_en = 1'b1;
      check("err_sticky", err_timeout, 1);
      run_job(16'h0F0F, 8'h13, 2, 1'b1, 0, 1'b0, 1'b0);
      do_cfg(4'd6, 6);

      // reset in the middle of a stream
      @(negedge clk);
      job_valid = 1'b1; job_act = 16'hABCD; job_w = 8'h2D;
      repeat (3) begin
         @(negedge clk);
         job_valid = 1'b0;
      end
      check("mid_stream", mul_valid, 1);
      rst = 1'b0;
      #1;
      check("rst_async", {mul_valid, mul_w, busy}, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_recfg", {mul_set, mul_precision}, {1'b1, 4'd8});
      cur_p = 8;
      @(negedge clk);
      check("rst_ready", job_ready, 1);
      run_job(16'h3555, 8'hC3, 2, 1'b0, 0, 1'b0, 1'b0);

      check("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
